// File: rtl/cflog_drain.sv
// cflog_drain: reader side of the CF-Log buffer.
// On a rising flush edge it snapshots the log pointer, emits an entry-count
// header, streams every logged 16-bit entry over valid/ready, then pulses
// log_clear so the monitor can restart logging.
module cflog_drain #(
  parameter logic [15:0] LOG_BASE = 16'h0000,
  parameter logic [15:0] LOG_SIZE = 16'h0100,
  parameter int          RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic [15:0] log_ptr,
  output logic        mem_rd_en,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        log_clear
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD,
    WT,
    TX,
    DONE
  } state_t;

  // Index of the last wait cycle; RAM data is sampled in that cycle.
  localparam logic [1:0] WT_LAST = 2'(RD_LAT - 1);

  state_t      state;
  logic        flush_q;
  logic [15:0] cnt_q;
  logic [14:0] idx_q;
  logic [1:0]  wt_cnt;

  logic        start;
  logic [15:0] clamped_ptr;
  logic [15:0] snap_cnt;
  logic [14:0] idx_nxt;
  logic        last_entry;

  // Start detection, pointer clamp and next-entry bookkeeping.
  always_comb begin
    start       = flush & ~flush_q & (state == IDLE);
    clamped_ptr = (log_ptr > LOG_SIZE) ? LOG_SIZE : log_ptr;
    snap_cnt    = clamped_ptr >> 1;
    idx_nxt     = idx_q + 15'd1;
    last_entry  = ({1'b0, idx_nxt} == cnt_q);
  end

  // Delayed copy of flush so only a rising edge starts a drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_q <= 1'b0;
    end else begin
      flush_q <= flush;
    end
  end

  // Drain sequencer with registered stream, RAM and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt_q     <= 16'h0000;
      idx_q     <= 15'd0;
      wt_cnt    <= 2'd0;
      mem_rd_en <= 1'b0;
      mem_addr  <= 16'h0000;
      out_data  <= 16'h0000;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      log_clear <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt_q     <= snap_cnt;
            idx_q     <= 15'd0;
            out_data  <= snap_cnt;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= HDR;
          end
        end

        HDR: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cnt_q == 16'h0000) begin
              log_clear <= 1'b1;
              state     <= DONE;
            end else begin
              mem_rd_en <= 1'b1;
              mem_addr  <= LOG_BASE;
              state     <= RD;
            end
          end
        end

        RD: begin
          mem_rd_en <= 1'b0;
          wt_cnt    <= 2'd0;
          state     <= WT;
        end

        WT: begin
          if (wt_cnt == WT_LAST) begin
            out_data  <= mem_rdata;
            out_valid <= 1'b1;
            state     <= TX;
          end else begin
            wt_cnt <= wt_cnt + 2'd1;
          end
        end

        TX: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_entry) begin
              log_clear <= 1'b1;
              state     <= DONE;
            end else begin
              idx_q     <= idx_nxt;
              mem_rd_en <= 1'b1;
              mem_addr  <= LOG_BASE + {idx_nxt, 1'b0};
              state     <= RD;
            end
          end
        end

        DONE: begin
          log_clear <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          mem_rd_en <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          log_clear <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cflog_drain.sv
// tb_cflog_drain: directed bench for cflog_drain with a 1-cycle RAM model.
module tb_cflog_drain;

  localparam logic [15:0] LOG_BASE = 16'h0000;
  localparam logic [15:0] LOG_SIZE = 16'h0008;
  localparam int          RD_LAT   = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [15:0] log_ptr;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        log_clear;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:127];

  logic [15:0] stream_q [$];
  int          hs_cyc [$];
  logic [15:0] addr_q [$];
  int          clear_count = 0;
  int          clear_cyc = 0;
  int          stall_viol = 0;
  int          cyc = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data = 16'h0000;

  logic [15:0] exp_basic [4] = '{16'h0003, 16'hA000, 16'hE010, 16'hE024};

  cflog_drain #(
    .LOG_BASE(LOG_BASE),
    .LOG_SIZE(LOG_SIZE),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .log_ptr  (log_ptr),
    .mem_rd_en(mem_rd_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .log_clear(log_clear)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // CF-Log RAM model: data returns one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr[7:1]];
  end

  // Stream, read and clear observer sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_viol++;
      if (out_valid && out_ready) begin
        stream_q.push_back(out_data);
        hs_cyc.push_back(cyc);
      end
      if (mem_rd_en) addr_q.push_back(mem_addr);
      if (log_clear) begin
        clear_count++;
        clear_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task clear_mon;
    stream_q.delete();
    hs_cyc.delete();
    addr_q.delete();
    clear_count = 0;
    stall_viol  = 0;
  endtask

  // Raise flush and step to just after the edge that starts the drain.
  task start_flush;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1;
  endtask

  task wait_idle(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task test_reset;
    reset_n = 1'b0; flush = 1'b0; log_ptr = 16'h0000; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_rd_en: got %b expected 0", mem_rd_en); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (log_clear !== 1'b0) begin errors++; $display("[TB] FAIL reset_log_clear: got %b expected 0", log_clear); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0000", out_data); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    clear_mon();
  endtask

  task test_basic_drain;
    bit ok;
    clear_mon();
    log_ptr = 16'h0006; out_ready = 1'b1;
    start_flush();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_rise: got %b expected 1", busy); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_hdr_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 16'h0003) begin errors++; $display("[TB] FAIL basic_hdr_data: got %h expected 0003", out_data); end
    @(posedge clk); #1 flush = 1'b0;
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_timeout: busy still %b expected 0", busy); end
    checks++; if (stream_q.size() != 4) begin errors++; $display("[TB] FAIL basic_stream_len: got %0d expected 4", stream_q.size()); end
    if (stream_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (stream_q[i] !== exp_basic[i]) begin errors++; $display("[TB] FAIL basic_stream[%0d]: got %h expected %h", i, stream_q[i], exp_basic[i]); end
      end
      checks++; if (hs_cyc[1] - hs_cyc[0] != 3) begin errors++; $display("[TB] FAIL basic_first_latency: got %0d expected 3", hs_cyc[1] - hs_cyc[0]); end
      checks++; if (hs_cyc[3] - hs_cyc[2] != 3) begin errors++; $display("[TB] FAIL basic_throughput: got %0d expected 3", hs_cyc[3] - hs_cyc[2]); end
      checks++; if (clear_cyc != hs_cyc[3] + 1) begin errors++; $display("[TB] FAIL basic_clear_timing: got %0d expected %0d", clear_cyc, hs_cyc[3] + 1); end
    end
    checks++; if (addr_q.size() != 3) begin errors++; $display("[TB] FAIL basic_read_count: got %0d expected 3", addr_q.size()); end
    if (addr_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (addr_q[i] !== 16'(2 * i)) begin errors++; $display("[TB] FAIL basic_addr[%0d]: got %h expected %h", i, addr_q[i], 16'(2 * i)); end
      end
    end
    checks++; if (clear_count != 1) begin errors++; $display("[TB] FAIL basic_clear_count: got %0d expected 1", clear_count); end
  endtask

  task test_empty_log;
    bit ok;
    clear_mon();
    log_ptr = 16'h0000; out_ready = 1'b1;
    start_flush();
    @(posedge clk); #1 flush = 1'b0;
    wait_idle(20, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL empty_timeout: busy still %b expected 0", busy); end
    checks++; if (stream_q.size() != 1) begin errors++; $display("[TB] FAIL empty_stream_len: got %0d expected 1", stream_q.size()); end
    if (stream_q.size() == 1) begin
      checks++; if (stream_q[0] !== 16'h0000) begin errors++; $display("[TB] FAIL empty_header: got %h expected 0000", stream_q[0]); end
    end
    checks++; if (addr_q.size() != 0) begin errors++; $display("[TB] FAIL empty_reads: got %0d expected 0", addr_q.size()); end
    checks++; if (clear_count != 1) begin errors++; $display("[TB] FAIL empty_clear_count: got %0d expected 1", clear_count); end
  endtask

  task test_clamp_odd;
    bit ok;
    logic [15:0] exp_clamp [5];
    exp_clamp = '{16'h0004, 16'hA000, 16'hE010, 16'hE024, 16'h1234};
    clear_mon();
    log_ptr = 16'h0013; out_ready = 1'b1;
    start_flush();
    @(posedge clk); #1 flush = 1'b0;
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL clamp_timeout: busy still %b expected 0", busy); end
    checks++; if (stream_q.size() != 5) begin errors++; $display("[TB] FAIL clamp_stream_len: got %0d expected 5", stream_q.size()); end
    if (stream_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (stream_q[i] !== exp_clamp[i]) begin errors++; $display("[TB] FAIL clamp_stream[%0d]: got %h expected %h", i, stream_q[i], exp_clamp[i]); end
      end
    end
    checks++; if (addr_q.size() != 4) begin errors++; $display("[TB] FAIL clamp_reads: got %0d expected 4", addr_q.size()); end
    if (addr_q.size() == 4) begin
      checks++; if (addr_q[3] !== 16'h0006) begin errors++; $display("[TB] FAIL clamp_last_addr: got %h expected 0006", addr_q[3]); end
    end
    checks++; if (clear_count != 1) begin errors++; $display("[TB] FAIL clamp_clear_count: got %0d expected 1", clear_count); end
  endtask

  task test_backpressure;
    bit done;
    done = 0;
    clear_mon();
    log_ptr = 16'h0006; out_ready = 1'b0;
    @(posedge clk); #1 flush = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (i == 2) flush = 1'b0;
      if (i % 3 == 2) out_ready = ~out_ready;
      if (i > 2 && !busy) begin
        done = 1;
        break;
      end
    end
    out_ready = 1'b1;
    checks++; if (!done) begin errors++; $display("[TB] FAIL bp_timeout: busy still %b expected 0", busy); end
    checks++; if (stream_q.size() != 4) begin errors++; $display("[TB] FAIL bp_stream_len: got %0d expected 4", stream_q.size()); end
    if (stream_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (stream_q[i] !== exp_basic[i]) begin errors++; $display("[TB] FAIL bp_stream[%0d]: got %h expected %h", i, stream_q[i], exp_basic[i]); end
      end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("[TB] FAIL bp_stall_stability: got %0d violations expected 0", stall_viol); end
    checks++; if (clear_count != 1) begin errors++; $display("[TB] FAIL bp_clear_count: got %0d expected 1", clear_count); end
  endtask

  task test_ignored_flush;
    bit ok;
    clear_mon();
    log_ptr = 16'h0006; out_ready = 1'b1;
    start_flush();
    @(posedge clk); #1 flush = 1'b0; log_ptr = 16'h0002;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ign_timeout: busy still %b expected 0", busy); end
    checks++; if (stream_q.size() != 4) begin errors++; $display("[TB] FAIL ign_stream_len: got %0d expected 4", stream_q.size()); end
    if (stream_q.size() == 4) begin
      checks++; if (stream_q[0] !== 16'h0003) begin errors++; $display("[TB] FAIL ign_header: got %h expected 0003", stream_q[0]); end
      checks++; if (stream_q[3] !== 16'hE024) begin errors++; $display("[TB] FAIL ign_last_entry: got %h expected e024", stream_q[3]); end
    end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_no_second_drain: busy got %b expected 0", busy); end
    checks++; if (clear_count != 1) begin errors++; $display("[TB] FAIL ign_clear_count: got %0d expected 1", clear_count); end
    clear_mon();
    start_flush();
    @(posedge clk); #1 flush = 1'b0;
    wait_idle(40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL retrig_timeout: busy still %b expected 0", busy); end
    checks++; if (stream_q.size() != 2) begin errors++; $display("[TB] FAIL retrig_stream_len: got %0d expected 2", stream_q.size()); end
    if (stream_q.size() == 2) begin
      checks++; if (stream_q[0] !== 16'h0001) begin errors++; $display("[TB] FAIL retrig_header: got %h expected 0001", stream_q[0]); end
      checks++; if (stream_q[1] !== 16'hA000) begin errors++; $display("[TB] FAIL retrig_entry: got %h expected a000", stream_q[1]); end
    end
    checks++; if (clear_count != 1) begin errors++; $display("[TB] FAIL retrig_clear_count: got %0d expected 1", clear_count); end
  endtask

  task test_reset_mid;
    bit ok;
    bit found;
    clear_mon();
    log_ptr = 16'h0006; out_ready = 1'b1;
    start_flush();
    @(posedge clk); #1 flush = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (stream_q.size() >= 2) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++; if (!found) begin errors++; $display("[TB] FAIL rst_first_entry: got %0d handshakes expected 2", stream_q.size()); end
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL rst_entry2_tx: out_valid got %b expected 1", out_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_rd_en: got %b expected 0", mem_rd_en); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (clear_count != 0) begin errors++; $display("[TB] FAIL rst_no_clear: got %0d expected 0", clear_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle_after: busy got %b expected 0", busy); end
    clear_mon();
    out_ready = 1'b1;
    start_flush();
    @(posedge clk); #1 flush = 1'b0;
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rst_redrain_timeout: busy still %b expected 0", busy); end
    checks++; if (stream_q.size() != 4) begin errors++; $display("[TB] FAIL rst_redrain_len: got %0d expected 4", stream_q.size()); end
    if (stream_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (stream_q[i] !== exp_basic[i]) begin errors++; $display("[TB] FAIL rst_redrain[%0d]: got %h expected %h", i, stream_q[i], exp_basic[i]); end
      end
    end
    checks++; if (clear_count != 1) begin errors++; $display("[TB] FAIL rst_redrain_clear: got %0d expected 1", clear_count); end
  endtask

  // Test sequence.
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'h5500 + 16'(i);
    mem[0] = 16'hA000;
    mem[1] = 16'hE010;
    mem[2] = 16'hE024;
    mem[3] = 16'h1234;
    test_reset();
    test_basic_drain();
    test_empty_log();
    test_clamp_odd();
    test_backpressure();
    test_ignored_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
